// File: rtl/pipe_cmd_dispatcher.sv
// Expands host PIPE commands into DW memory requests and returns one response record per read beat or per command.
// Defining PIPE_DISP_STATS_EN adds saturating command/timeout/drop counters.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | ready for a new host command
// S_ISSUE    | presenting the current beat's memory request
// S_WAIT_CPL | read request issued, waiting for matching completion or timeout
// S_RST_HOLD | holding soft_rst_n low
// S_RESP     | presenting a registered response record to the host interface
module pipe_cmd_dispatcher #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RESET_CYCLES   = 16,
    parameter int MAX_LEN        = 256
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_type,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [15:0] cmd_len,
    input  logic [7:0]  cmd_tag,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_wr,
    output logic [31:0] req_addr,
    output logic [31:0] req_data,
    output logic [7:0]  req_tag,
    input  logic        cpl_valid,
    input  logic [7:0]  cpl_tag,
    input  logic [31:0] cpl_data,
    input  logic [7:0]  cpl_status,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_type,
    output logic [31:0] rsp_read_data,
    output logic [7:0]  rsp_tag,
    output logic [7:0]  rsp_status,
    output logic [31:0] rsp_timestamp,
    output logic        soft_rst_n,
    output logic        busy
`ifdef PIPE_DISP_STATS_EN
    ,
    output logic [15:0] stat_cmds,
    output logic [15:0] stat_timeouts,
    output logic [15:0] stat_drops
`endif
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RS_W  = $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_CPL, S_RST_HOLD, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              run_q;
    logic [7:0]        type_q, tag_q;
    logic [31:0]       addr_q, data_q, ts_q;
    logic [LEN_W-1:0]  len_q, beat_q, beat_nxt, len_d;
    logic [TO_W-1:0]   to_cnt_q;
    logic [RS_W-1:0]   rst_cnt_q;
    logic              soft_rst_q, tmo_q, tmo_d;
    logic              rsp_load;
    logic [7:0]        rsp_type_d, rsp_tag_d, rsp_status_d;
    logic [31:0]       rsp_data_d;
    logic [7:0]        cur_tag;
    logic              cmd_hs, cpl_hit, to_exp, last_beat, rst_done;

    assign cur_tag   = tag_q + 8'(beat_q);
    assign beat_nxt  = beat_q + LEN_W'(1);
    assign last_beat = (beat_nxt == len_q);
    assign cmd_hs    = cmd_valid & cmd_ready;
    assign cpl_hit   = (state_q == S_WAIT_CPL) & cpl_valid & (cpl_tag == cur_tag);
    assign to_exp    = (state_q == S_WAIT_CPL) & (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign rst_done  = (rst_cnt_q == RS_W'(RESET_CYCLES - 1));

    always_comb begin
        if (cmd_len == 16'd0)
            len_d = LEN_W'(1);
        else if ({16'd0, cmd_len} > 32'(MAX_LEN))
            len_d = LEN_W'(MAX_LEN);
        else
            len_d = LEN_W'(cmd_len);
    end

    assign cmd_ready     = run_q & (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign req_valid     = (state_q == S_ISSUE);
    assign req_wr        = (type_q == 8'h02);
    assign req_addr      = (addr_q & 32'hFFFF_FFFC) + 32'({beat_q, 2'b00});
    assign req_data      = data_q;
    assign req_tag       = cur_tag;
    assign rsp_valid     = (state_q == S_RESP);
    assign soft_rst_n    = soft_rst_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        rsp_load     = 1'b0;
        tmo_d        = 1'b0;
        rsp_type_d   = 8'h00;
        rsp_data_d   = 32'd0;
        rsp_tag_d    = 8'h00;
        rsp_status_d = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    case (cmd_type)
                        8'h01, 8'h02: state_d = S_ISSUE;
                        8'h03:        state_d = S_RST_HOLD;
                        default: begin
                            state_d      = S_RESP;
                            rsp_load     = 1'b1;
                            rsp_type_d   = 8'hFF;
                            rsp_tag_d    = cmd_tag;
                            rsp_status_d = 8'h01;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                if (req_ready) begin
                    if (type_q != 8'h02) begin
                        state_d = S_WAIT_CPL;
                    end else if (last_beat) begin
                        state_d    = S_RESP;
                        rsp_load   = 1'b1;
                        rsp_type_d = 8'h82;
                        rsp_tag_d  = tag_q;
                    end
                end
            end
            S_WAIT_CPL: begin
                // a matching completion on the expiry cycle still counts as data
                if (cpl_hit) begin
                    state_d      = S_RESP;
                    rsp_load     = 1'b1;
                    rsp_type_d   = 8'h81;
                    rsp_data_d   = cpl_data;
                    rsp_tag_d    = cur_tag;
                    rsp_status_d = cpl_status;
                end else if (to_exp) begin
                    state_d      = S_RESP;
                    rsp_load     = 1'b1;
                    tmo_d        = 1'b1;
                    rsp_type_d   = 8'h81;
                    rsp_tag_d    = cur_tag;
                    rsp_status_d = 8'h02;
                end
            end
            S_RST_HOLD: begin
                if (rst_done) begin
                    state_d    = S_RESP;
                    rsp_load   = 1'b1;
                    rsp_type_d = 8'h83;
                    rsp_tag_d  = tag_q;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if ((type_q == 8'h01) && !tmo_q && !last_beat)
                        state_d = S_ISSUE;
                    else
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            run_q         <= 1'b0;
            ts_q          <= 32'd0;
            type_q        <= 8'h00;
            addr_q        <= 32'd0;
            data_q        <= 32'd0;
            tag_q         <= 8'h00;
            len_q         <= '0;
            beat_q        <= '0;
            to_cnt_q      <= '0;
            rst_cnt_q     <= '0;
            soft_rst_q    <= 1'b1;
            tmo_q         <= 1'b0;
            rsp_type      <= 8'h00;
            rsp_read_data <= 32'd0;
            rsp_tag       <= 8'h00;
            rsp_status    <= 8'h00;
            rsp_timestamp <= 32'd0;
        end else begin
            run_q <= 1'b1;
            ts_q  <= ts_q + 32'd1;
            if (cmd_hs) begin
                type_q <= cmd_type;
                addr_q <= cmd_addr;
                data_q <= cmd_data;
                tag_q  <= cmd_tag;
                len_q  <= len_d;
                beat_q <= '0;
                if (cmd_type == 8'h03) begin
                    soft_rst_q <= 1'b0;
                    rst_cnt_q  <= '0;
                end
            end
            if ((state_q == S_ISSUE) && req_ready) begin
                to_cnt_q <= '0;
                if (type_q == 8'h02)
                    beat_q <= beat_nxt;
            end
            if ((state_q == S_WAIT_CPL) && !to_exp)
                to_cnt_q <= to_cnt_q + TO_W'(1);
            if (state_q == S_RST_HOLD) begin
                if (rst_done)
                    soft_rst_q <= 1'b1;
                else
                    rst_cnt_q <= rst_cnt_q + RS_W'(1);
            end
            if ((state_q == S_RESP) && rsp_ready && (type_q == 8'h01))
                beat_q <= beat_nxt;
            // timestamp is the counter value seen during the first RESP cycle
            if (rsp_load) begin
                tmo_q         <= tmo_d;
                rsp_type      <= rsp_type_d;
                rsp_read_data <= rsp_data_d;
                rsp_tag       <= rsp_tag_d;
                rsp_status    <= rsp_status_d;
                rsp_timestamp <= ts_q + 32'd1;
            end
        end
    end

`ifdef PIPE_DISP_STATS_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stat_cmds     <= 16'd0;
            stat_timeouts <= 16'd0;
            stat_drops    <= 16'd0;
        end else begin
            if (cmd_hs && (stat_cmds != 16'hFFFF))
                stat_cmds <= stat_cmds + 16'd1;
            if (to_exp && !cpl_hit && (stat_timeouts != 16'hFFFF))
                stat_timeouts <= stat_timeouts + 16'd1;
            if (cpl_valid && !cpl_hit && (stat_drops != 16'hFFFF))
                stat_drops <= stat_drops + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_cmd_dispatcher.sv
// Scoreboard bench for pipe_cmd_dispatcher: stimulus pushes expected requests/responses, negedge monitors pop and compare.
module tb_pipe_cmd_dispatcher;
    localparam int T = 1024;
    localparam int R = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_type = 8'h00;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_data = 32'd0;
    logic [15:0] cmd_len = 16'd0;
    logic [7:0]  cmd_tag = 8'h00;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [7:0]  req_tag;
    logic        cpl_valid = 1'b0;
    logic [7:0]  cpl_tag = 8'h00;
    logic [31:0] cpl_data = 32'd0;
    logic [7:0]  cpl_status = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_type;
    logic [31:0] rsp_read_data;
    logic [7:0]  rsp_tag;
    logic [7:0]  rsp_status;
    logic [31:0] rsp_timestamp;
    logic        soft_rst_n;
    logic        busy;
`ifdef PIPE_DISP_STATS_EN
    logic [15:0] stat_cmds, stat_timeouts, stat_drops;
`endif

    always #5 sys_clk = ~sys_clk;

    pipe_cmd_dispatcher #(.TIMEOUT_CYCLES(T), .RESET_CYCLES(R), .MAX_LEN(256)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len), .cmd_tag(cmd_tag),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
        .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_data(cpl_data), .cpl_status(cpl_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type),
        .rsp_read_data(rsp_read_data), .rsp_tag(rsp_tag), .rsp_status(rsp_status),
        .rsp_timestamp(rsp_timestamp), .soft_rst_n(soft_rst_n), .busy(busy)
`ifdef PIPE_DISP_STATS_EN
        , .stat_cmds(stat_cmds), .stat_timeouts(stat_timeouts), .stat_drops(stat_drops)
`endif
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  tag;
    } req_t;
    typedef struct {
        logic [7:0]  typ;
        logic [31:0] data;
        logic [7:0]  tag;
        logic [7:0]  st;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];
    int nvec = 0;
    int nerr = 0;
    logic [31:0] cyc;
    logic [31:0] last_acc = 32'd0;

    always @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) cyc <= 32'd0;
        else            cyc <= cyc + 32'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    task automatic push_req(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [7:0] tag);
        req_t e;
        e.wr = wr; e.addr = addr; e.data = data; e.tag = tag;
        exp_req.push_back(e);
    endtask

    task automatic push_rsp(input logic [7:0] typ, input logic [31:0] data, input logic [7:0] tag, input logic [7:0] st);
        rsp_t e;
        e.typ = typ; e.data = data; e.tag = tag; e.st = st;
        exp_rsp.push_back(e);
    endtask

    // request monitor: scoreboard pop on handshake, stability while stalled
    bit   req_held = 0;
    req_t req_hold;
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            req_held = 0;
        end else if (req_valid) begin
            if (req_held) begin
                chk("req_stable_addr", req_addr, req_hold.addr);
                chk("req_stable_tag", req_tag, req_hold.tag);
                chk("req_stable_wr", req_wr, req_hold.wr);
                chk("req_stable_data", req_data, req_hold.data);
            end
            if (req_ready) begin
                last_acc = cyc + 32'd1;
                if (exp_req.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL req_unexpected: got addr %0h tag %0h, required no request", req_addr, req_tag);
                end else begin
                    req_t e;
                    e = exp_req.pop_front();
                    chk("req_wr", req_wr, e.wr);
                    chk("req_addr", req_addr, e.addr);
                    chk("req_data", req_data, e.data);
                    chk("req_tag", req_tag, e.tag);
                end
                req_held = 0;
            end else begin
                req_held = 1;
                req_hold.wr = req_wr; req_hold.addr = req_addr;
                req_hold.data = req_data; req_hold.tag = req_tag;
            end
        end else begin
            req_held = 0;
        end
    end

    // response monitor
    bit   rsp_held = 0;
    rsp_t rsp_hold;
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            rsp_held = 0;
        end else if (rsp_valid) begin
            if (!rsp_held) begin
                chk("rsp_timestamp", rsp_timestamp, cyc);
                if (exp_rsp.size() > 0 && exp_rsp[0].st == 8'h02)
                    chk("timeout_latency", cyc - last_acc, T);
            end else begin
                chk("rsp_stable_type", rsp_type, rsp_hold.typ);
                chk("rsp_stable_data", rsp_read_data, rsp_hold.data);
                chk("rsp_stable_tag", rsp_tag, rsp_hold.tag);
                chk("rsp_stable_status", rsp_status, rsp_hold.st);
            end
            if (rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL rsp_unexpected: got type %0h tag %0h, required no response", rsp_type, rsp_tag);
                end else begin
                    rsp_t e;
                    e = exp_rsp.pop_front();
                    chk("rsp_type", rsp_type, e.typ);
                    chk("rsp_data", rsp_read_data, e.data);
                    chk("rsp_tag", rsp_tag, e.tag);
                    chk("rsp_status", rsp_status, e.st);
                end
                rsp_held = 0;
            end else begin
                rsp_held = 1;
                rsp_hold.typ = rsp_type; rsp_hold.data = rsp_read_data;
                rsp_hold.tag = rsp_tag; rsp_hold.st = rsp_status;
            end
        end else begin
            rsp_held = 0;
        end
    end

    int low_cnt = 0;
    int soft_pulses = 0;
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            low_cnt = 0;
        end else if (!soft_rst_n) begin
            low_cnt++;
        end else if (low_cnt != 0) begin
            chk("soft_rst_width", low_cnt, R);
            soft_pulses++;
            low_cnt = 0;
        end
    end

    task automatic send_cmd(input logic [7:0] typ, input logic [31:0] addr, input logic [31:0] data,
                            input logic [15:0] len, input logic [7:0] tag);
        bit ok;
        ok = 0;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b1; cmd_type = typ; cmd_addr = addr; cmd_data = data; cmd_len = len; cmd_tag = tag;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) fail_now("cmd_accept");
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req_hs();
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sys_clk);
            if (req_valid && req_ready) begin ok = 1; break; end
        end
        if (!ok) fail_now("req_handshake");
        @(posedge sys_clk); #1;
    endtask

    task automatic wait_rsp_valid();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (rsp_valid) begin ok = 1; break; end
        end
        if (!ok) fail_now("rsp_valid_wait");
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (!busy && !rsp_valid) begin ok = 1; break; end
        end
        if (!ok) fail_now("idle_wait");
        @(posedge sys_clk); #1;
    endtask

    task automatic pulse_cpl(input logic [7:0] tag, input logic [31:0] data, input logic [7:0] st);
        cpl_valid = 1'b1; cpl_tag = tag; cpl_data = data; cpl_status = st;
        @(posedge sys_clk); #1;
        cpl_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        repeat (3) @(negedge sys_clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_soft_rst_n", soft_rst_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_timestamp", rsp_timestamp, 0);
        chk("rst_rsp_type", rsp_type, 0);
        chk("rst_req_addr", req_addr, 0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;

        // write, 3 beats
        req_ready = 1'b1;
        push_req(1'b1, 32'h1000, 32'hDEADBEEF, 8'h10);
        push_req(1'b1, 32'h1004, 32'hDEADBEEF, 8'h11);
        push_req(1'b1, 32'h1008, 32'hDEADBEEF, 8'h12);
        push_rsp(8'h82, 32'h0, 8'h10, 8'h00);
        send_cmd(8'h02, 32'h1000, 32'hDEADBEEF, 16'd3, 8'h10);
        wait_idle(100);

        // read, 2 beats, stalled request, tag wrap, nonzero status proceeds
        req_ready = 1'b0;
        push_req(1'b0, 32'h2000, 32'h12345678, 8'hFE);
        push_req(1'b0, 32'h2004, 32'h12345678, 8'hFF);
        push_rsp(8'h81, 32'hA5A50001, 8'hFE, 8'h05);
        push_rsp(8'h81, 32'h5A5A0002, 8'hFF, 8'h00);
        send_cmd(8'h01, 32'h2000, 32'h12345678, 16'd2, 8'hFE);
        repeat (2) @(posedge sys_clk); #1;
        pulse_cpl(8'hFE, 32'hBAD0BAD0, 8'h00);
        repeat (2) @(posedge sys_clk); #1;
        req_ready = 1'b1;
        wait_req_hs();
        repeat (3) @(posedge sys_clk); #1;
        pulse_cpl(8'hFE, 32'hA5A50001, 8'h05);
        wait_req_hs();
        repeat (2) @(posedge sys_clk); #1;
        pulse_cpl(8'hFF, 32'h5A5A0002, 8'h00);
        wait_idle(100);

        // read timeout aborts remaining beats
        push_req(1'b0, 32'h3000, 32'h0, 8'h40);
        push_rsp(8'h81, 32'h0, 8'h40, 8'h02);
        send_cmd(8'h01, 32'h3000, 32'h0, 16'd4, 8'h40);
        wait_idle(T + 200);
        repeat (20) @(posedge sys_clk);
        #1;
        chk("busy_after_timeout", busy, 0);

        // wrong tag dropped; matching completion on the expiry cycle wins
        push_req(1'b0, 32'h4000, 32'h0, 8'h77);
        push_rsp(8'h81, 32'hCAFEF00D, 8'h77, 8'h00);
        send_cmd(8'h01, 32'h4000, 32'h0, 16'd1, 8'h77);
        wait_req_hs();
        a = cyc;
        repeat (4) @(posedge sys_clk); #1;
        pulse_cpl(8'h78, 32'h11111111, 8'h00);
        while (cyc < a + T - 1) begin
            @(posedge sys_clk); #1;
        end
        pulse_cpl(8'h77, 32'hCAFEF00D, 8'h00);
        wait_idle(100);

        // soft reset command
        push_rsp(8'h83, 32'h0, 8'h33, 8'h00);
        send_cmd(8'h03, 32'h0, 32'h0, 16'd1, 8'h33);
        wait_idle(100);
        chk("soft_rst_pulses", soft_pulses, 1);

        // unsupported command, response held under back-pressure
        rsp_ready = 1'b0;
        push_rsp(8'hFF, 32'h0, 8'h5C, 8'h01);
        send_cmd(8'h7A, 32'h9000, 32'h1234, 16'd1, 8'h5C);
        wait_rsp_valid();
        repeat (10) @(posedge sys_clk); #1;
        rsp_ready = 1'b1;
        wait_idle(50);

        // length clamp to 256, address and tag wrap, low address bits ignored
        for (int i = 0; i < 256; i++)
            push_req(1'b1, 32'hFFFFFF00 + 32'(i * 4), 32'h0000C1A9, 8'hF0 + 8'(i));
        push_rsp(8'h82, 32'h0, 8'hF0, 8'h00);
        send_cmd(8'h02, 32'hFFFFFF03, 32'h0000C1A9, 16'd300, 8'hF0);
        wait_idle(400);

        // asynchronous reset mid-ISSUE
        req_ready = 1'b0;
        send_cmd(8'h02, 32'h5000, 32'h0000FACE, 16'd2, 8'h09);
        @(negedge sys_clk);
        chk("busy_before_rst", busy, 1);
        chk("req_valid_before_rst", req_valid, 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_req_valid", req_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cmd_ready", cmd_ready, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_soft_rst_n", soft_rst_n, 1);
        chk("arst_req_addr", req_addr, 0);
        chk("arst_timestamp", rsp_timestamp, 0);
`ifdef PIPE_DISP_STATS_EN
        chk("arst_stat_cmds", stat_cmds, 0);
        chk("arst_stat_timeouts", stat_timeouts, 0);
        chk("arst_stat_drops", stat_drops, 0);
`endif
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        req_ready = 1'b1;

        // recovery, zero length treated as one beat
        push_req(1'b1, 32'h6000, 32'h00000077, 8'h20);
        push_rsp(8'h82, 32'h0, 8'h20, 8'h00);
        send_cmd(8'h02, 32'h6000, 32'h00000077, 16'd0, 8'h20);
        wait_idle(100);
        repeat (5) @(posedge sys_clk);
        #1;

        chk("exp_req_left", exp_req.size(), 0);
        chk("exp_rsp_left", exp_rsp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
